// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: mem_we pulses the cycle after a word's 4th byte; done/error follow one cycle after the last write/check byte.
// Backpressure: in_ready is high only in LOAD/CHECK; in_valid stalls of any length freeze the counters (no timeout).
// Build option: define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte with CHECK/ERROR states.
module imem_loader #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  count_m1,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  // Word index width; the +2 byte-offset bits are appended when forming mem_addr.
  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LAST_IDX = 32'(DEPTH_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CHECK = 3'd4,
    S_ERROR = 3'd5
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;            // last word index of the current load (clamped)
  logic [AW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     asm_q, asm_d;            // bytes 0..2 of the word being assembled
  logic [63:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;            // running XOR of every accepted data byte
`endif

  logic            start_ok;
  logic            byte_fire;
  logic            last_word;
  logic [31:0]     cnt_wide;
  logic [AW-1:0]   cnt_clamp;

  // Qualify start, detect data-byte transfers and clamp the requested length to the memory depth.
  always_comb begin
    start_ok = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: start_ok = start;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_ERROR:        start_ok = start;
`endif
      default:        start_ok = 1'b0;
    endcase
    byte_fire = in_valid && (state_q == S_LOAD);
    last_word = (word_idx_q == cnt_q);
    cnt_wide  = 32'(count_m1);
    if (cnt_wide >= LAST_IDX) begin
      cnt_clamp = LAST_IDX[AW-1:0];
    end else begin
      cnt_clamp = cnt_wide[AW-1:0];
    end
  end

  // FSM state register; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (byte_fire && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (in_valid) state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
      end
      S_ERROR: begin
        if (start_ok) state_d = S_LOAD;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: all status flags and strobes decode directly from the state.
  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
`endif
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath next values: counters, byte assembly, checksum and the held write address/data.
  always_comb begin
    cnt_d       = cnt_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    if (start_ok) begin
      cnt_d      = cnt_clamp;
      word_idx_d = '0;
      byte_idx_d = 2'd0;
      asm_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d      = 8'd0;
`endif
    end else if (byte_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d = chk_q ^ in_data;
`endif
      case (byte_idx_q)
        2'd0: asm_d[7:0]   = in_data;
        2'd1: asm_d[15:8]  = in_data;
        2'd2: asm_d[23:16] = in_data;
        default: begin
          // Fourth byte completes the word; capture address and data so they
          // are valid during WRITE and held afterwards.
          mem_addr_d  = 64'({word_idx_q, 2'b00});
          mem_wdata_d = {in_data, asm_q};
        end
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
    end else if (state_q == S_WRITE) begin
      byte_idx_d = 2'd0;
      if (!last_word) word_idx_d = word_idx_q + AW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= 2'd0;
      asm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= 8'd0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed loads with a write scoreboard.
// Stimulus pushes expected (addr, data) writes; a negedge monitor pops and compares on every mem_we.
// Status flags are compared directly from the stimulus thread at quiet points.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  count_m1;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(256)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .count_m1 (count_m1),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_pass   = 0;
  int          n_total  = 0;
  int          n_writes = 0;
  logic [63:0] last_addr = 64'd0;
  logic        mon_en   = 1'b0;
  logic [7:0]  run_chk  = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mon_en && !reset && mem_we) begin
      n_writes++;
      last_addr = mem_addr;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e.addr);
        check("write_data", {32'd0, mem_wdata}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Offer one byte after 'gap' idle cycles; returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL byte_accept: in_ready stayed 0 for byte 0x%0h, expected 1", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] c);
    start    = 1'b1;
    count_m1 = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [63:0] a, input int gap, input bit poke);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (poke && k == 2) pulse_start(8'd3);
      send_byte(w[8*k +: 8], gap);
      run_chk = run_chk ^ w[8*k +: 8];
    end
  endtask

  // Trailing checksum byte exists only in the checksum build.
  task automatic finish_load(input logic [7:0] chk_byte, input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(chk_byte, gap);
`else
    if (chk_byte != chk_byte) send_byte(chk_byte, gap);
`endif
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (!(done || error) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(done || error)) begin
      n_total++;
      $display("FAIL load_end: done/error never rose (busy=%0d), expected completion", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_demo(input int gap, input logic [7:0] chk_byte);
    run_chk = 8'd0;
    pulse_start(8'd1);
    send_word(32'h0070_0013, 64'h0, gap, 1'b0);
    send_word(32'h0DC0_0693, 64'h4, gap, 1'b0);
    finish_load(chk_byte, gap);
    wait_end();
  endtask

  initial begin
    int w0;
    reset    = 1'b1;
    start    = 1'b0;
    count_m1 = 8'd0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Normal two-word load (checksum of the stream is 0x3B).
    w0 = n_writes;
    run_chk = 8'd0;
    pulse_start(8'd1);
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_hold_busy", cpu_hold, 1'b1);
    @(posedge clk);
    #1;
    send_word(32'h0070_0013, 64'h0, 0, 1'b0);
    send_word(32'h0DC0_0693, 64'h4, 0, 1'b0);
    check("t1_tb_chk", run_chk, 8'h3B);
    finish_load(8'h3B, 0);
    wait_end();
    check("t1_done", done, 1'b1);
    check("t1_error", error, 1'b0);
    check("t1_cpu_hold", cpu_hold, 1'b0);
    check("t1_busy_end", busy, 1'b0);
    check("t1_we_idle", mem_we, 1'b0);
    check("t1_addr_hold", mem_addr, 64'h4);
    check("t1_wdata_hold", mem_wdata, 32'h0DC0_0693);
    check("t1_nwrites", n_writes - w0, 2);

    // Same stream with 5-cycle stalls before every byte; restart from DONE.
    w0 = n_writes;
    pulse_start(8'd1);
    @(negedge clk);
    check("t2_hold_reassert", cpu_hold, 1'b1);
    check("t2_done_clear", done, 1'b0);
    @(posedge clk);
    #1;
    run_chk = 8'd0;
    send_word(32'h0070_0013, 64'h0, 5, 1'b0);
    send_word(32'h0DC0_0693, 64'h4, 5, 1'b0);
    finish_load(8'h3B, 5);
    wait_end();
    check("t2_nwrites", n_writes - w0, 2);
    check("t2_done", done, 1'b1);

    // Reset after two bytes of word 1, asserted together with start.
    w0 = n_writes;
    run_chk = 8'd0;
    pulse_start(8'd1);
    send_word(32'h0070_0013, 64'h0, 0, 1'b0);
    send_byte(8'h93, 0);
    send_byte(8'h06, 0);
    @(negedge clk);
    check("t3_hold_mid", cpu_hold, 1'b1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    start    = 1'b1;
    count_m1 = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t3_busy_after_rst", busy, 1'b0);
    check("t3_ready_after_rst", in_ready, 1'b0);
    check("t3_hold_after_rst", cpu_hold, 1'b1);
    check("t3_done_after_rst", done, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_aborted_writes", n_writes - w0, 1);
    run_chk = 8'd0;
    pulse_start(8'd0);
    send_word(32'h1234_5678, 64'h0, 0, 1'b0);
    check("t3_tb_chk", run_chk, 8'h08);
    @(negedge clk);
    check("t3_hold_reload", cpu_hold, 1'b1);
    @(posedge clk);
    #1;
    finish_load(8'h08, 0);
    wait_end();
    check("t3_done", done, 1'b1);
    check("t3_nwrites", n_writes - w0, 2);

    // Full depth with an ignored start pulse in the middle of word 100.
    w0 = n_writes;
    run_chk = 8'd0;
    pulse_start(8'd255);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_word({8'hC3, ~b, b ^ 8'h5A, b}, 64'(i) << 2, 0, (i == 100));
    end
    finish_load(run_chk, 0);
    wait_end();
    check("t4_nwrites", n_writes - w0, 256);
    check("t4_last_addr", last_addr, 64'h3FC);
    check("t4_done", done, 1'b1);
    check("t4_hold", cpu_hold, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum byte, then a clean retry.
    load_demo(0, 8'h3A);
    check("t5_error", error, 1'b1);
    check("t5_done", done, 1'b0);
    check("t5_hold", cpu_hold, 1'b1);
    check("t5_busy", busy, 1'b0);
    load_demo(0, 8'h3B);
    check("t5_retry_done", done, 1'b1);
    check("t5_retry_error", error, 1'b0);
    check("t5_retry_hold", cpu_hold, 1'b0);
`else
    load_demo(1, 8'h3B);
    check("t5_error_tied", error, 1'b0);
    check("t5_done", done, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
